opb_cmd_master: RTL and testbench
=================================

OPB_CMD_MASTER -- requirements
Module: opb_cmd_master

Interface
REQ-001 Parameter C_TIMEOUT, default 16, sets the number of cycles in XFER without an acknowledge before the transfer is aborted (minimum 2).
REQ-002 Parameter C_MAX_RETRY, default 3, sets the re-issues allowed after OPB_retry (1..15).
REQ-003 OPB_Clk  in  1  sole clock; one clock; all logic on its rising edge.
REQ-004 OPB_Rst_n  in  1  reset, synchronous, active-low.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake; a command is accepted when both are high.
REQ-006 cmd_addr  in  32  byte address of the command.
REQ-007 cmd_wdata  in  32  write data of the command.
REQ-008 cmd_be  in  4  byte enables of the command.
REQ-009 cmd_rnw  in  1  1 = read, 0 = write.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  32  read data; zero for writes and for failed transfers.
REQ-012 rsp_status  out  2  0 = OK, 1 = ERR, 2 = TIMEOUT, 3 = RETRY_EXHAUSTED.
REQ-013 M_request, M_select, M_RNW, M_seqAddr, M_busLock  out  1 each  OPB master controls.
REQ-014 M_ABus [0:31], M_BE [0:3], M_DBus [0:31]  out  master address, byte enable and data buses.
REQ-015 OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry  in  1 each  arbiter grant and slave responses.
REQ-016 OPB_DBus  in  [0:31]  read data bus.

Function
REQ-017 States SHALL be IDLE, REQ, XFER, RESP.
- IDLE: cmd_ready=1; on accept, latch the command and go to REQ.
- REQ: M_request=1; on OPB_MGrant go to XFER next cycle.
- XFER: M_select=1 and buses driven.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
REQ-018 In XFER, OPB_xferAck SHALL complete with OK; for reads, OPB_DBus SHALL be captured in the same cycle.
REQ-019 In XFER, OPB_errAck SHALL complete with ERR; if xferAck and errAck arrive in the same cycle, errAck SHALL take priority.
REQ-020 In XFER, OPB_retry SHALL deassert M_select next cycle, increment the retry count and return to REQ (see REQ-030); retry SHALL take priority over xferAck and errAck.
REQ-021 The XFER cycle counter SHALL reset on entry to XFER; at C_TIMEOUT cycles without a response, go to RESP with status TIMEOUT.
REQ-022 The accepted command SHALL become bus-visible (M_select=1) no earlier than 2 cycles after accept, given immediate grant.
REQ-023 A transfer with immediate grant and xferAck on the first XFER cycle SHALL pulse rsp_valid 4 cycles after accept.
REQ-024 M_ABus, M_BE and M_DBus SHALL be zero whenever M_select=0 (OR-bus rule); M_DBus SHALL be zero during reads.
REQ-025 M_seqAddr and M_busLock SHALL be tied to 0.
REQ-026 cmd_ready SHALL be 0 in every state except IDLE; there is exactly one outstanding command.
REQ-027 M_request SHALL drop in the cycle in which the grant is observed.

Reset
REQ-028 With OPB_Rst_n=0 at a clock edge: state=IDLE; all M_* outputs=0; rsp_valid=0; rsp_rdata=0; rsp_status=0; retry count=0; timeout counter=0.
REQ-029 Reset mid-transfer SHALL abandon the command silently (no rsp_valid), and cmd_ready=1 SHALL follow on the first cycle after reset release.

Configuration
REQ-030 Macro OPB_CMD_MASTER_RETRY_EN:
- Defined: OPB_retry re-issues up to C_MAX_RETRY times; a retry beyond that ends with RETRY_EXHAUSTED.
- Undefined: the first OPB_retry ends the transfer immediately with RETRY_EXHAUSTED; no retry counter is synthesized.

Structure
REQ-031 Shared package opb_master_pkg SHALL hold the state enum, the rsp_status encodings and the default C_TIMEOUT.
REQ-032 The timeout counter SHALL be a sub-module, opb_watchdog (inputs clear, enable; output expired).

Verification
REQ-033 Write: addr 0x10, wdata 0x1, be 0xF, grant and xferAck immediate.
- M_select high for one cycle with M_ABus=0x10 and M_DBus=0x00000001.
- rsp_valid with status 0 four cycles after accept.
REQ-034 Read: addr 0x4, slave returns 0x00000101 with xferAck on the third XFER cycle -> rsp_rdata=0x00000101, status 0; M_DBus=0 throughout.
REQ-035 xferAck and errAck asserted together -> status 1, rsp_rdata=0.
REQ-036 No response with C_TIMEOUT=16 -> rsp_valid exactly 16 XFER cycles after M_select rises, status 2.
REQ-037 Retry, with the macro defined and C_MAX_RETRY=3:
- Three retries then xferAck -> status 0, with four M_select episodes.
- Four retries -> status 3.
- Macro undefined: one retry -> status 3.
REQ-038 OPB_Rst_n low during XFER -> all M_* outputs 0 next cycle, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/opb_master_pkg.sv
// Shared types and defaults for the OPB command master: FSM states,
// response status encodings and default parameter values.
package opb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RSP_OK              = 2'd0,
    RSP_ERR             = 2'd1,
    RSP_TIMEOUT         = 2'd2,
    RSP_RETRY_EXHAUSTED = 2'd3
  } rsp_status_e;

  localparam int unsigned C_TIMEOUT_DEFAULT   = 16;
  localparam int unsigned C_MAX_RETRY_DEFAULT = 3;

endpackage

// File: rtl/opb_cmd_master_if.sv
// Command/response handshake plus OPB master-side bus bundle.
// The master modport is the opb_cmd_master view; slave is the environment view.
interface opb_cmd_master_if;
  import opb_master_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        cmd_rnw;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  rsp_status_e rsp_status;

  logic        M_request;
  logic        M_select;
  logic        M_RNW;
  logic        M_seqAddr;
  logic        M_busLock;
  logic [0:31] M_ABus;
  logic [0:3]  M_BE;
  logic [0:31] M_DBus;

  logic        OPB_MGrant;
  logic        OPB_xferAck;
  logic        OPB_errAck;
  logic        OPB_retry;
  logic [0:31] OPB_DBus;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_be, cmd_rnw,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_status,
    output M_request, M_select, M_RNW, M_seqAddr, M_busLock, M_ABus, M_BE, M_DBus,
    input  OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_DBus
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_be, cmd_rnw,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_status,
    input  M_request, M_select, M_RNW, M_seqAddr, M_busLock, M_ABus, M_BE, M_DBus,
    output OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_DBus
  );

endinterface

// File: rtl/opb_watchdog.sv
// Transfer watchdog: counts enabled cycles since the last clear and flags
// the C_TIMEOUT-th enabled cycle as expired.
module opb_watchdog
  import opb_master_pkg::*;
#(
  parameter int unsigned C_TIMEOUT = C_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CNT_W = $clog2(C_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(C_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating count so a stuck enable cannot wrap back below LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/opb_cmd_master.sv
// Single-outstanding OPB master turning command-port requests into bus transfers.
// Define OPB_CMD_MASTER_RETRY_EN to re-issue on OPB_retry up to C_MAX_RETRY times.
module opb_cmd_master
  import opb_master_pkg::*;
#(
  parameter int unsigned C_TIMEOUT   = C_TIMEOUT_DEFAULT,
  parameter int unsigned C_MAX_RETRY = C_MAX_RETRY_DEFAULT
) (
  input  logic             OPB_Clk,
  input  logic             OPB_Rst_n,
  opb_cmd_master_if.master bus
);

  if ((C_TIMEOUT < 2) || (C_MAX_RETRY < 1) || (C_MAX_RETRY > 15)) begin : g_param_check
    $error("opb_cmd_master: C_TIMEOUT must be >= 2 and C_MAX_RETRY within 1..15");
  end

  state_e      state_q, state_d;
  logic        grant_seen_q, grant_seen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rnw_q, rnw_d;
  logic [31:0] rdata_q, rdata_d;
  rsp_status_e status_q, status_d;
  logic        accept;
  logic        retry_reissue;
  logic        wd_expired;

  assign accept = (state_q == ST_IDLE) && bus.cmd_valid;

`ifdef OPB_CMD_MASTER_RETRY_EN
  logic [3:0] retry_cnt_q, retry_cnt_d;

  assign retry_reissue = (retry_cnt_q != 4'(C_MAX_RETRY));

  always_comb begin
    retry_cnt_d = retry_cnt_q;
    if (accept) begin
      retry_cnt_d = 4'd0;
    end else if ((state_q == ST_XFER) && bus.OPB_retry && retry_reissue) begin
      retry_cnt_d = retry_cnt_q + 4'd1;
    end else begin
      retry_cnt_d = retry_cnt_q;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      retry_cnt_q <= 4'd0;
    end else begin
      retry_cnt_q <= retry_cnt_d;
    end
  end
`else
  assign retry_reissue = 1'b0;
`endif

  opb_watchdog #(
    .C_TIMEOUT (C_TIMEOUT)
  ) u_watchdog (
    .clk     (OPB_Clk),
    .rst_n   (OPB_Rst_n),
    .clear   (state_q != ST_XFER),
    .enable  (state_q == ST_XFER),
    .expired (wd_expired)
  );

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Slave response priority in XFER: retry, then errAck, then xferAck, then timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = bus.cmd_valid ? ST_REQ : ST_IDLE;
      ST_REQ:  state_d = grant_seen_q ? ST_XFER : ST_REQ;
      ST_XFER: begin
        if (bus.OPB_retry) begin
          state_d = retry_reissue ? ST_REQ : ST_RESP;
        end else if (bus.OPB_errAck || bus.OPB_xferAck || wd_expired) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, grant tracking and completion result capture.
  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rnw_d        = rnw_q;
    rdata_d      = rdata_q;
    status_d     = status_q;
    grant_seen_d = (state_q == ST_REQ) && (grant_seen_q || bus.OPB_MGrant);
    if (accept) begin
      addr_d  = bus.cmd_addr;
      wdata_d = bus.cmd_wdata;
      be_d    = bus.cmd_be;
      rnw_d   = bus.cmd_rnw;
    end else if (state_q == ST_XFER) begin
      if (bus.OPB_retry) begin
        if (!retry_reissue) begin
          status_d = RSP_RETRY_EXHAUSTED;
          rdata_d  = 32'h0000_0000;
        end else begin
          status_d = status_q;
        end
      end else if (bus.OPB_errAck) begin
        status_d = RSP_ERR;
        rdata_d  = 32'h0000_0000;
      end else if (bus.OPB_xferAck) begin
        status_d = RSP_OK;
        rdata_d  = rnw_q ? bus.OPB_DBus : 32'h0000_0000;
      end else if (wd_expired) begin
        status_d = RSP_TIMEOUT;
        rdata_d  = 32'h0000_0000;
      end else begin
        status_d = status_q;
      end
    end else begin
      status_d = status_q;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      grant_seen_q <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      be_q         <= 4'h0;
      rnw_q        <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      status_q     <= RSP_OK;
    end else begin
      grant_seen_q <= grant_seen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rnw_q        <= rnw_d;
      rdata_q      <= rdata_d;
      status_q     <= status_d;
    end
  end

  // Bus outputs stay zero outside XFER so they can be ORed onto the shared OPB.
  always_comb begin
    bus.cmd_ready  = (state_q == ST_IDLE) && OPB_Rst_n;
    bus.M_request  = (state_q == ST_REQ) && !grant_seen_q && !bus.OPB_MGrant;
    bus.M_seqAddr  = 1'b0;
    bus.M_busLock  = 1'b0;
    bus.M_select   = 1'b0;
    bus.M_RNW      = 1'b0;
    bus.M_ABus     = 32'h0000_0000;
    bus.M_BE       = 4'h0;
    bus.M_DBus     = 32'h0000_0000;
    bus.rsp_valid  = (state_q == ST_RESP);
    bus.rsp_rdata  = rdata_q;
    bus.rsp_status = status_q;
    if (state_q == ST_XFER) begin
      bus.M_select = 1'b1;
      bus.M_RNW    = rnw_q;
      bus.M_ABus   = addr_q;
      bus.M_BE     = be_q;
      bus.M_DBus   = rnw_q ? 32'h0000_0000 : wdata_q;
    end else begin
      bus.M_select = 1'b0;
    end
  end

endmodule

// File: tb/tb_opb_cmd_master.sv
// Directed self-checking bench for opb_cmd_master with a scripted OPB slave/arbiter.
module tb_opb_cmd_master;
  import opb_master_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  opb_cmd_master_if bif ();

  opb_cmd_master #(
    .C_TIMEOUT   (16),
    .C_MAX_RETRY (3)
  ) dut (
    .OPB_Clk   (clk),
    .OPB_Rst_n (rst_n),
    .bus       (bif.master)
  );

  // Observations of the most recent run_cmd transaction.
  logic        o_ready0, o_after_valid, o_after_ready;
  int          o_sel_first, o_sel_cycles, o_sel_eps, o_rsp_cyc, o_bus_bad, o_req_bad, o_ready_bad;
  logic [1:0]  o_status;
  logic [31:0] o_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.cmd_valid   = 1'b0;
    bif.OPB_MGrant  = 1'b0;
    bif.OPB_xferAck = 1'b0;
    bif.OPB_errAck  = 1'b0;
    bif.OPB_retry   = 1'b0;
    bif.OPB_DBus    = 32'h0;
  endtask

  // Issue one command; grant immediately, answer per script, record what the bus did.
  task automatic run_cmd(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                         input logic rnw, input int ack_at, input int err_at, input int n_retry,
                         input logic [31:0] rd);
    int ep_cyc = 0;
    int retried = 0;
    logic prev_sel = 1'b0;
    o_sel_first = -1; o_sel_cycles = 0; o_sel_eps = 0; o_rsp_cyc = -1;
    o_bus_bad = 0; o_req_bad = 0; o_ready_bad = 0; o_status = 2'd0; o_rdata = 32'h0;
    tick();
    clear_inputs();
    bif.cmd_valid = 1'b1; bif.cmd_addr = addr; bif.cmd_wdata = wdata; bif.cmd_be = be; bif.cmd_rnw = rnw;
    #1;
    o_ready0 = bif.cmd_ready;
    for (int c = 1; c <= 60; c++) begin
      tick();
      clear_inputs();
      #1;
      if (bif.M_request) begin
        bif.OPB_MGrant = 1'b1;
        #1;
        if (bif.M_request !== 1'b0) o_req_bad++;
      end
      if (bif.M_select) begin
        if (!prev_sel) begin
          o_sel_eps++;
          ep_cyc = 0;
          if (o_sel_first < 0) o_sel_first = c;
        end
        ep_cyc++;
        o_sel_cycles++;
        if (bif.M_ABus !== addr || bif.M_BE !== be || bif.M_RNW !== rnw) o_bus_bad++;
        if (bif.M_DBus !== (rnw ? 32'h0 : wdata)) o_bus_bad++;
        if (retried < n_retry && ep_cyc == 1) begin
          bif.OPB_retry = 1'b1;
          retried++;
        end else begin
          if (ep_cyc == ack_at) begin
            bif.OPB_xferAck = 1'b1;
            if (rnw) bif.OPB_DBus = rd;
          end
          if (ep_cyc == err_at) bif.OPB_errAck = 1'b1;
        end
      end else begin
        if (bif.M_ABus !== 32'h0 || bif.M_BE !== 4'h0 || bif.M_DBus !== 32'h0) o_bus_bad++;
      end
      if (bif.M_seqAddr !== 1'b0 || bif.M_busLock !== 1'b0) o_bus_bad++;
      if (bif.cmd_ready !== 1'b0) o_ready_bad++;
      prev_sel = bif.M_select;
      if (bif.rsp_valid === 1'b1) begin
        o_rsp_cyc = c;
        o_status  = bif.rsp_status;
        o_rdata   = bif.rsp_rdata;
        break;
      end
    end
    tick();
    clear_inputs();
    #1;
    o_after_valid = bif.rsp_valid;
    o_after_ready = bif.cmd_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bif.cmd_addr = 32'h0; bif.cmd_wdata = 32'h0; bif.cmd_be = 4'h0; bif.cmd_rnw = 1'b0;
    repeat (3) tick();
    total++; if ({bif.M_request, bif.M_select, bif.M_RNW, bif.M_seqAddr, bif.M_busLock} !== 5'b0) begin bad++; $display("FAIL reset_mctl got=%b exp=00000", {bif.M_request, bif.M_select, bif.M_RNW, bif.M_seqAddr, bif.M_busLock}); end
    total++; if (bif.M_ABus !== 32'h0 || bif.M_BE !== 4'h0 || bif.M_DBus !== 32'h0) begin bad++; $display("FAIL reset_mbus got=%h/%h/%h exp=0", bif.M_ABus, bif.M_BE, bif.M_DBus); end
    total++; if (bif.rsp_valid !== 1'b0 || bif.rsp_rdata !== 32'h0 || bif.rsp_status !== 2'd0) begin bad++; $display("FAIL reset_rsp got=%b/%h/%0d exp=0", bif.rsp_valid, bif.rsp_rdata, bif.rsp_status); end
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (bif.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bif.cmd_ready); end
  endtask

  task automatic test_write();
    run_cmd(32'h10, 32'h1, 4'hF, 1'b0, 1, 0, 0, 32'h0);
    total++; if (o_ready0 !== 1'b1) begin bad++; $display("FAIL wr_accept got=%b exp=1", o_ready0); end
    total++; if (o_sel_first !== 3) begin bad++; $display("FAIL wr_sel_first got=%0d exp=3", o_sel_first); end
    total++; if (o_sel_cycles !== 1) begin bad++; $display("FAIL wr_sel_cycles got=%0d exp=1", o_sel_cycles); end
    total++; if (o_bus_bad !== 0) begin bad++; $display("FAIL wr_bus got=%0d exp=0", o_bus_bad); end
    total++; if (o_req_bad !== 0) begin bad++; $display("FAIL wr_req_drop got=%0d exp=0", o_req_bad); end
    total++; if (o_ready_bad !== 0) begin bad++; $display("FAIL wr_ready_busy got=%0d exp=0", o_ready_bad); end
    total++; if (o_rsp_cyc !== 4) begin bad++; $display("FAIL wr_rsp_cyc got=%0d exp=4", o_rsp_cyc); end
    total++; if (o_status !== 2'd0 || o_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp got=%0d/%h exp=0/0", o_status, o_rdata); end
    total++; if (o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin bad++; $display("FAIL wr_after got=%b/%b exp=0/1", o_after_valid, o_after_ready); end
  endtask

  task automatic test_read();
    run_cmd(32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1, 3, 0, 0, 32'h0000_0101);
    total++; if (o_sel_cycles !== 3) begin bad++; $display("FAIL rd_sel_cycles got=%0d exp=3", o_sel_cycles); end
    total++; if (o_bus_bad !== 0) begin bad++; $display("FAIL rd_bus got=%0d exp=0", o_bus_bad); end
    total++; if (o_rsp_cyc !== 6) begin bad++; $display("FAIL rd_rsp_cyc got=%0d exp=6", o_rsp_cyc); end
    total++; if (o_status !== 2'd0 || o_rdata !== 32'h0000_0101) begin bad++; $display("FAIL rd_rsp got=%0d/%h exp=0/00000101", o_status, o_rdata); end
  endtask

  task automatic test_err();
    run_cmd(32'h20, 32'h0, 4'h3, 1'b1, 2, 2, 0, 32'hCAFE_F00D);
    total++; if (o_sel_cycles !== 2) begin bad++; $display("FAIL err_sel_cycles got=%0d exp=2", o_sel_cycles); end
    total++; if (o_status !== 2'd1 || o_rdata !== 32'h0) begin bad++; $display("FAIL err_rsp got=%0d/%h exp=1/0", o_status, o_rdata); end
  endtask

  task automatic test_timeout();
    run_cmd(32'h30, 32'h5A5A_A5A5, 4'hF, 1'b0, 0, 0, 0, 32'h0);
    total++; if (o_sel_cycles !== 16) begin bad++; $display("FAIL to_sel_cycles got=%0d exp=16", o_sel_cycles); end
    total++; if (o_rsp_cyc - o_sel_first !== 16) begin bad++; $display("FAIL to_latency got=%0d exp=16", o_rsp_cyc - o_sel_first); end
    total++; if (o_status !== 2'd2 || o_rdata !== 32'h0) begin bad++; $display("FAIL to_rsp got=%0d/%h exp=2/0", o_status, o_rdata); end
  endtask

  task automatic test_retry();
`ifdef OPB_CMD_MASTER_RETRY_EN
    run_cmd(32'h50, 32'h1234_0000, 4'hF, 1'b0, 1, 0, 3, 32'h0);
    total++; if (o_sel_eps !== 4) begin bad++; $display("FAIL rty3_episodes got=%0d exp=4", o_sel_eps); end
    total++; if (o_rsp_cyc !== 13 || o_status !== 2'd0) begin bad++; $display("FAIL rty3_rsp got=%0d/%0d exp=13/0", o_rsp_cyc, o_status); end
    run_cmd(32'h54, 32'h0, 4'hF, 1'b1, 1, 0, 4, 32'h7777_7777);
    total++; if (o_sel_eps !== 4) begin bad++; $display("FAIL rty4_episodes got=%0d exp=4", o_sel_eps); end
    total++; if (o_rsp_cyc !== 13 || o_status !== 2'd3 || o_rdata !== 32'h0) begin bad++; $display("FAIL rty4_rsp got=%0d/%0d/%h exp=13/3/0", o_rsp_cyc, o_status, o_rdata); end
`else
    run_cmd(32'h50, 32'h1234_0000, 4'hF, 1'b0, 1, 0, 1, 32'h0);
    total++; if (o_sel_eps !== 1) begin bad++; $display("FAIL rty1_episodes got=%0d exp=1", o_sel_eps); end
    total++; if (o_rsp_cyc !== 4 || o_status !== 2'd3) begin bad++; $display("FAIL rty1_rsp got=%0d/%0d exp=4/3", o_rsp_cyc, o_status); end
`endif
  endtask

  task automatic test_reset_mid();
    int seen_sel = 0;
    int rsp_seen = 0;
    tick();
    clear_inputs();
    bif.cmd_valid = 1'b1; bif.cmd_addr = 32'h40; bif.cmd_wdata = 32'h55; bif.cmd_be = 4'hF; bif.cmd_rnw = 1'b0;
    for (int c = 1; c <= 10 && seen_sel == 0; c++) begin
      tick();
      clear_inputs();
      #1;
      if (bif.M_request) begin
        bif.OPB_MGrant = 1'b1;
        #1;
      end
      if (bif.M_select === 1'b1) seen_sel = 1;
    end
    total++; if (seen_sel !== 1) begin bad++; $display("FAIL rstm_reached_xfer got=%0d exp=1", seen_sel); end
    rst_n = 1'b0;
    tick();
    total++; if ({bif.M_request, bif.M_select, bif.M_RNW} !== 3'b0 || bif.M_ABus !== 32'h0 || bif.M_DBus !== 32'h0 || bif.M_BE !== 4'h0) begin bad++; $display("FAIL rstm_mout got=%b/%h/%h exp=0", {bif.M_request, bif.M_select, bif.M_RNW}, bif.M_ABus, bif.M_DBus); end
    if (bif.rsp_valid !== 1'b0) rsp_seen++;
    tick();
    if (bif.rsp_valid !== 1'b0) rsp_seen++;
    rst_n = 1'b1;
    #1;
    total++; if (bif.cmd_ready !== 1'b1) begin bad++; $display("FAIL rstm_ready got=%b exp=1", bif.cmd_ready); end
    tick();
    if (bif.rsp_valid !== 1'b0) rsp_seen++;
    total++; if (rsp_seen !== 0) begin bad++; $display("FAIL rstm_silent got=%0d exp=0", rsp_seen); end
  endtask

  task automatic test_back_to_back();
    run_cmd(32'h100, 32'hA5A5_5A5A, 4'hC, 1'b0, 2, 0, 0, 32'h0);
    total++; if (o_rsp_cyc !== 5 || o_status !== 2'd0 || o_bus_bad !== 0) begin bad++; $display("FAIL b2b_wr got=%0d/%0d/%0d exp=5/0/0", o_rsp_cyc, o_status, o_bus_bad); end
    run_cmd(32'h104, 32'h0, 4'h1, 1'b1, 1, 0, 0, 32'h1234_5678);
    total++; if (o_rsp_cyc !== 4 || o_rdata !== 32'h1234_5678 || o_bus_bad !== 0) begin bad++; $display("FAIL b2b_rd got=%0d/%h/%0d exp=4/12345678/0", o_rsp_cyc, o_rdata, o_bus_bad); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_write();
    test_read();
    test_err();
    test_timeout();
    test_retry();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
